// File: rtl/pattern_resp_misr.sv
// Response-compaction stage: folds a run of response vectors into a MISR signature.
// It then holds the signature and flags done, along with a compare against a golden value.
module pattern_resp_misr #(
  parameter int                WIDTH = 10,
  parameter int                SIG_W = 16,
  parameter int                CNT_W = 8,
  parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED  = 16'h0000
) (
  input  logic             blif_clk_net_r,
  input  logic             blif_reset_net_r,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_pat_i,
  input  logic             resp_valid_i,
  input  logic [WIDTH-1:0] resp_data_i,
  output logic             resp_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SIG_W-1:0] sig_o,
  output logic [CNT_W-1:0] pat_cnt_o,
  input  logic [SIG_W-1:0] exp_sig_i,
  output logic             match_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [SIG_W-1:0] sig, sig_shift, sig_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc, target;
  logic             load, accept;

  // Galois-style step: shift, fold POLY back in on MSB carry-out, then inject the vector.
  assign sig_shift = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0);
  assign sig_nxt   = sig_shift ^ SIG_W'(resp_data_i);
  assign cnt_inc   = cnt + CNT_W'(1);

  always_ff @(posedge blif_clk_net_r or posedge blif_reset_net_r) begin
    if (blif_reset_net_r) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    resp_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    load         = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done_o = (state == DONE);
        if (start_i) begin
          load      = 1'b1;
          state_nxt = (num_pat_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        resp_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (resp_valid_i) begin
          accept = 1'b1;
          if (cnt_inc == target) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Target is only consumed in RUN, so a zero-length run leaves it untouched.
  always_ff @(posedge blif_clk_net_r or posedge blif_reset_net_r) begin
    if (blif_reset_net_r) begin
      sig    <= SEED;
      cnt    <= '0;
      target <= '0;
    end else if (load) begin
      sig <= SEED;
      cnt <= '0;
      if (num_pat_i != '0) target <= num_pat_i;
    end else if (accept) begin
      sig <= sig_nxt;
      cnt <= cnt_inc;
    end
  end

  assign sig_o     = sig;
  assign pat_cnt_o = cnt;
  assign match_o   = done_o & (sig == exp_sig_i);

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Directed bench for pattern_resp_misr: expected signatures are queued as runs are issued
// and popped when the DUT reports done.
module tb_pattern_resp_misr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, valid = 1'b0;
  logic [7:0]  num_pat = '0;
  logic [9:0]  data = '0;
  logic [15:0] exp_sig = '0;
  logic        ready, busy, done, match;
  logic [15:0] sig;
  logic [7:0]  cnt;

  logic        b_start = 1'b0, b_valid = 1'b0;
  logic [7:0]  b_num = '0;
  logic [9:0]  b_data = '0;
  logic        b_ready, b_busy, b_done, b_match;
  logic [15:0] b_sig;
  logic [7:0]  b_cnt;

  int tests = 0, fails = 0;
  logic [15:0] sig_q[$];
  logic [7:0]  cnt_q[$];

  always #5 clk = ~clk;

  pattern_resp_misr dut (
    .blif_clk_net_r(clk), .blif_reset_net_r(rst), .start_i(start), .num_pat_i(num_pat),
    .resp_valid_i(valid), .resp_data_i(data), .resp_ready_o(ready), .busy_o(busy),
    .done_o(done), .sig_o(sig), .pat_cnt_o(cnt), .exp_sig_i(exp_sig), .match_o(match));

  pattern_resp_misr #(.SEED(16'h8000)) dut_b (
    .blif_clk_net_r(clk), .blif_reset_net_r(rst), .start_i(b_start), .num_pat_i(b_num),
    .resp_valid_i(b_valid), .resp_data_i(b_data), .resp_ready_o(b_ready), .busy_o(b_busy),
    .done_o(b_done), .sig_o(b_sig), .pat_cnt_o(b_cnt), .exp_sig_i(16'h1021), .match_o(b_match));

  function automatic logic [15:0] step(input logic [15:0] s, input logic [9:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {6'b0, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [7:0] n);
    start = 1'b1; num_pat = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [9:0] d);
    int w;
    valid = 1'b1; data = d; w = 0;
    while (!ready && w < 20) begin tick(); w++; end
    check("send_ready", {31'b0, ready}, 32'd1);
    tick();
    valid = 1'b0;
  endtask

  task automatic score(input string tag);
    int w;
    w = 0;
    while (!done && w < 50) begin tick(); w++; end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    if (sig_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      check({tag, "_sig"}, {16'b0, sig}, {16'b0, sig_q.pop_front()});
      check({tag, "_cnt"}, {24'b0, cnt}, {24'b0, cnt_q.pop_front()});
    end
  endtask

  initial begin
    logic [15:0] m;
    rst = 1'b1;
    tick(); tick();
    check("rst_sig", {16'b0, sig}, 32'h0);
    check("rst_cnt", {24'b0, cnt}, 32'h0);
    check("rst_flags", {28'b0, ready, busy, done, match}, 32'h0);
    check("rst_b_sig", {16'b0, b_sig}, 32'h8000);
    rst = 1'b0;
    tick();

    // 1) single vector
    sig_q.push_back(16'h03FF); cnt_q.push_back(8'd1);
    start_run(8'd1);
    check("t1_busy_ready", {30'b0, busy, ready}, 32'h3);
    send(10'h3FF);
    check("t1_done_next", {31'b0, done}, 32'd1);
    check("t1_ready_low", {31'b0, ready}, 32'd0);
    score("t1");

    // 2) two vectors, golden compare
    sig_q.push_back(16'h07FF); cnt_q.push_back(8'd2);
    start_run(8'd2);
    send(10'h3FF); send(10'h001);
    score("t2");
    exp_sig = 16'h07FF; #1;
    check("t2_match", {31'b0, match}, 32'd1);
    exp_sig = 16'h07FE; #1;
    check("t2_nomatch", {31'b0, match}, 32'd0);

    // 3) feedback path on the SEED=8000 instance
    b_start = 1'b1; b_num = 8'd1;
    tick();
    b_start = 1'b0; b_valid = 1'b1; b_data = 10'h000;
    check("t3_ready", {31'b0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    check("t3_done", {31'b0, b_done}, 32'd1);
    check("t3_sig", {16'b0, b_sig}, 32'h1021);
    check("t3_match", {31'b0, b_match}, 32'd1);

    // 4) valid gap mid-run, valid held past the last accept
    m = step(16'h0, 10'h2A5);
    sig_q.push_back(step(step(m, 10'h15A), 10'h0F0)); cnt_q.push_back(8'd3);
    start_run(8'd3);
    send(10'h2A5);
    for (int i = 0; i < 4; i++) begin
      check("t4_gap_cnt", {24'b0, cnt}, 32'd1);
      check("t4_gap_sig", {16'b0, sig}, {16'b0, m});
      tick();
    end
    send(10'h15A);
    valid = 1'b1; data = 10'h0F0;
    tick();
    data = 10'h3C3;
    for (int i = 0; i < 2; i++) begin
      check("t4_no_extra_ready", {31'b0, ready}, 32'd0);
      check("t4_no_extra_cnt", {24'b0, cnt}, 32'd3);
      tick();
    end
    valid = 1'b0;
    score("t4");

    // 5) zero-length run, then start ignored in RUN
    start_run(8'd0);
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_sig_seed", {16'b0, sig}, 32'h0);
    check("t5_cnt", {24'b0, cnt}, 32'd0);
    sig_q.push_back(step(step(16'h0, 10'h011), 10'h222)); cnt_q.push_back(8'd2);
    start_run(8'd2);
    start = 1'b1; num_pat = 8'd5;
    tick();
    start = 1'b0;
    check("t5_start_ignored", {31'b0, busy}, 32'd1);
    send(10'h011); send(10'h222);
    score("t5");

    // 6) reset mid-run, then a clean run
    start_run(8'd5);
    send(10'h3FF); send(10'h155);
    check("t6_pre_cnt", {24'b0, cnt}, 32'd2);
    #2 rst = 1'b1; #1;
    check("t6_rst_sig", {16'b0, sig}, 32'h0);
    check("t6_rst_cnt", {24'b0, cnt}, 32'h0);
    check("t6_rst_flags", {28'b0, ready, busy, done, match}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle", {29'b0, ready, busy, done}, 32'h0);
    m = step(step(step(16'h0, 10'h3FF), 10'h155), 10'h2AA);
    sig_q.push_back(m); cnt_q.push_back(8'd3);
    exp_sig = m;
    start_run(8'd3);
    send(10'h3FF); send(10'h155); send(10'h2AA);
    score("t6");
    check("t6_match", {31'b0, match}, 32'd1);
    check("sb_drained", sig_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
